barrel_pipe: RTL and testbench

BARREL_PIPE -- requirements
Module: barrel_pipe

---
 rtl/barrel_pkg.sv | 23 ++
 rtl/barrel_stage.sv | 74 +++++++
 rtl/barrel_pipe.sv | 152 +++++++++++++++
 tb/tb_barrel_pipe.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/barrel_pkg.sv
// -----------------------------------------------------------------------------
// barrel_pkg
// Shared definitions for the pipelined barrel shifter:
//   mode_e : shift/rotate operation selector (LSL, LSR, ASR, ROR)
//   clog2  : ceiling log2, used to size the shift-amount field
// -----------------------------------------------------------------------------
package barrel_pkg;

   typedef enum logic [1:0] {
      MODE_LSL = 2'd0,
      MODE_LSR = 2'd1,
      MODE_ASR = 2'd2,
      MODE_ROR = 2'd3
   } mode_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/barrel_stage.sv
// -----------------------------------------------------------------------------
// barrel_stage
// Combinational slice of the barrel shifter covering shift levels
// LO .. LO+N-1. Level k shifts by 2**k when bit k of the shift amount is set.
// Levels are applied low to high, so the bit shifted out by the highest active
// level is exactly the overall last bit shifted out; the carry is only
// overwritten by an active level, leaving 0 for a zero shift.
//
// Ports:
//   i_mode   operation (mode_e)
//   i_fill   bit inserted into vacated positions (sign bit for ASR)
//   i_sft    full shift amount; only bits LO..LO+N-1 are acted on here
//   i_data   partial result from the previous slice
//   i_carry  partial carry from the previous slice
//   o_data   partial result after this slice
//   o_carry  partial carry after this slice
// -----------------------------------------------------------------------------
module barrel_stage
   import barrel_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SW    = 5,
   parameter int LO    = 0,
   parameter int N     = 1
) (
   input  mode_e            i_mode,
   input  logic             i_fill,
   input  logic [SW-1:0]    i_sft,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_carry,
   output logic [WIDTH-1:0] o_data,
   output logic             o_carry
);

   logic [WIDTH-1:0] w_fill_vec;
   logic [WIDTH-1:0] w_d;
   logic [WIDTH-1:0] w_t;
   logic             w_c;

   assign w_fill_vec = {WIDTH{i_fill}};

   always_comb begin
      w_d = i_data;
      w_c = i_carry;
      w_t = '0;
      for (int k = LO; k < LO + N; k++) begin
         if (i_sft[k]) begin
            case (i_mode)
               MODE_LSL: begin
                  // last bit out is the one that reaches the MSB after 2**k-1 shifts
                  w_t = w_d << ((1 << k) - 1);
                  w_c = w_t[WIDTH-1];
                  w_d = (w_d << (1 << k)) | (w_fill_vec >> (WIDTH - (1 << k)));
               end
               MODE_LSR, MODE_ASR: begin
                  w_t = w_d >> ((1 << k) - 1);
                  w_c = w_t[0];
                  w_d = (w_d >> (1 << k)) | (w_fill_vec << (WIDTH - (1 << k)));
               end
               default: begin
                  // ROR: the bit landing in the MSB is the one rotated out
                  w_t = w_d >> ((1 << k) - 1);
                  w_c = w_t[0];
                  w_d = (w_d >> (1 << k)) | (w_d << (WIDTH - (1 << k)));
               end
            endcase
         end
      end
   end

   assign o_data  = w_d;
   assign o_carry = w_c;

endmodule

// File: rtl/barrel_pipe.sv
// -----------------------------------------------------------------------------
// barrel_pipe
// Pipelined barrel shifter/rotator with valid/ready handshaking on both sides.
// The SW shift levels are split over STAGES register stages (ceil(SW/STAGES)
// levels each, the last stage takes what is left). Each stage register holds
// valid, mode, fill bit, shift amount, partial data and partial carry.
//
// Ports:
//   sys_clk    clock, rising edge
//   resetl     asynchronous active-low reset
//   clr        synchronous flush of all in-flight operations
//   in_valid   operation offered
//   in_ready   operation accepted when in_valid & in_ready
//   mux        mode: 0 LSL, 1 LSR, 2 ASR, 3 ROR
//   sft        shift amount 0..WIDTH-1
//   flin       fill bit for LSL/LSR
//   a          operand
//   out_valid  result present
//   out_ready  result consumed when out_valid & out_ready
//   z          result
//   co         last bit shifted/rotated out
//   zf         z equals zero
// -----------------------------------------------------------------------------
module barrel_pipe
   import barrel_pkg::*;
#(
   parameter  int WIDTH  = 32,
   parameter  int STAGES = 2,
   localparam int SW     = clog2(WIDTH)
) (
   input  logic             sys_clk,
   input  logic             resetl,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       mux,
   input  logic [SW-1:0]    sft,
   input  logic             flin,
   input  logic [WIDTH-1:0] a,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] z,
   output logic             co,
   output logic             zf
);

   localparam int PER = (SW + STAGES - 1) / STAGES;

   logic [STAGES-1:0] r_vld;
   mode_e             r_mode  [STAGES];
   logic              r_fill  [STAGES];
   logic [SW-1:0]     r_sft   [STAGES];
   logic [WIDTH-1:0]  r_data  [STAGES];
   logic              r_carry [STAGES];
   logic              r_zf;

   logic [STAGES-1:0] w_adv;
   logic [STAGES-1:0] w_src_vld;
   mode_e             w_src_mode  [STAGES];
   logic              w_src_fill  [STAGES];
   logic [SW-1:0]     w_src_sft   [STAGES];
   logic [WIDTH-1:0]  w_src_data  [STAGES];
   logic              w_src_carry [STAGES];
   logic [WIDTH-1:0]  w_nxt_data  [STAGES];
   logic              w_nxt_carry [STAGES];

   // Stage inputs: stage 0 takes the ports, later stages the previous register.
   always_comb begin
      w_src_vld[0]   = in_valid;
      w_src_mode[0]  = mode_e'(mux);
      w_src_fill[0]  = (mode_e'(mux) == MODE_ASR) ? a[WIDTH-1] : flin;
      w_src_sft[0]   = sft;
      w_src_data[0]  = a;
      w_src_carry[0] = 1'b0;
      for (int s = 1; s < STAGES; s++) begin
         w_src_vld[s]   = r_vld[s-1];
         w_src_mode[s]  = r_mode[s-1];
         w_src_fill[s]  = r_fill[s-1];
         w_src_sft[s]   = r_sft[s-1];
         w_src_data[s]  = r_data[s-1];
         w_src_carry[s] = r_carry[s-1];
      end
   end

   // Ready chain: a stage may load when it is empty or its contents move on.
   always_comb begin
      w_adv = '0;
      w_adv[STAGES-1] = ~r_vld[STAGES-1] | out_ready;
      for (int s = STAGES - 2; s >= 0; s--) begin
         w_adv[s] = ~r_vld[s] | w_adv[s+1];
      end
   end

   assign in_ready = w_adv[0];

   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      localparam int LO = g * PER;
      localparam int N  = (LO >= SW) ? 0 : ((SW - LO < PER) ? (SW - LO) : PER);

      barrel_stage #(
         .WIDTH (WIDTH),
         .SW    (SW),
         .LO    (LO),
         .N     (N)
      ) u_stage (
         .i_mode  (w_src_mode[g]),
         .i_fill  (w_src_fill[g]),
         .i_sft   (w_src_sft[g]),
         .i_data  (w_src_data[g]),
         .i_carry (w_src_carry[g]),
         .o_data  (w_nxt_data[g]),
         .o_carry (w_nxt_carry[g])
      );
   end

   // ---- pipeline registers: stage s captures the output of slice s ----
   always_ff @(posedge sys_clk or negedge resetl) begin
      if (!resetl) begin
         r_vld <= '0;
         r_zf  <= 1'b0;
         for (int s = 0; s < STAGES; s++) begin
            r_mode[s]  <= MODE_LSL;
            r_fill[s]  <= 1'b0;
            r_sft[s]   <= '0;
            r_data[s]  <= '0;
            r_carry[s] <= 1'b0;
         end
      end else begin
         for (int s = 0; s < STAGES; s++) begin
            if (w_adv[s]) r_vld[s] <= w_src_vld[s];
            if (w_adv[s] && w_src_vld[s]) begin
               r_mode[s]  <= w_src_mode[s];
               r_fill[s]  <= w_src_fill[s];
               r_sft[s]   <= w_src_sft[s];
               r_data[s]  <= w_nxt_data[s];
               r_carry[s] <= w_nxt_carry[s];
            end
         end
         if (w_adv[STAGES-1] && w_src_vld[STAGES-1]) begin
            r_zf <= (w_nxt_data[STAGES-1] == '0);
         end
         // flush wins over any handshake in the same cycle
         if (clr) r_vld <= '0;
      end
   end

   assign out_valid = r_vld[STAGES-1];
   assign z         = r_data[STAGES-1];
   assign co        = r_carry[STAGES-1];
   assign zf        = r_zf;

endmodule

// File: tb/tb_barrel_pipe.sv
module tb_barrel_pipe;

   logic        sys_clk = 1'b0;
   logic        resetl  = 1'b1;
   logic        clr     = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  mux  = 2'd0;
   logic [4:0]  sft  = 5'd0;
   logic        flin = 1'b0;
   logic [31:0] a    = 32'h0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] z;
   logic        co;
   logic        zf;

   int n_pass  = 0;
   int n_total = 0;
   int n_out   = 0;
   bit done    = 1'b0;
   logic [33:0] q[$];
   logic        hold_v = 1'b0;
   logic [33:0] hold   = '0;

   barrel_pipe #(.WIDTH(32), .STAGES(2)) dut (
      .sys_clk   (sys_clk),
      .resetl    (resetl),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mux       (mux),
      .sft       (sft),
      .flin      (flin),
      .a         (a),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .z         (z),
      .co        (co),
      .zf        (zf)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Reference result {zf, co, z} straight from the operation definitions.
   function automatic logic [33:0] model(input logic [1:0] m, input int s,
                                         input logic f, input logic [31:0] av);
      logic [31:0] r;
      logic        c;
      logic        fb;
      r = av;
      c = 1'b0;
      if (s != 0) begin
         case (m)
            2'd0: begin
               r = (av << s) | (f ? (32'hFFFF_FFFF >> (32 - s)) : 32'h0);
               c = av[32 - s];
            end
            2'd1, 2'd2: begin
               fb = (m == 2'd2) ? av[31] : f;
               r = (av >> s) | (fb ? ~(32'hFFFF_FFFF >> s) : 32'h0);
               c = av[s - 1];
            end
            default: begin
               r = (av >> s) | (av << (32 - s));
               c = r[31];
            end
         endcase
      end
      return {(r == 32'h0), c, r};
   endfunction

   // Scoreboard: evaluates the handshakes that will happen at the next rising edge.
   always @(negedge sys_clk) begin
      if (!resetl) begin
         q.delete();
         hold_v = 1'b0;
      end else begin
         if (hold_v) chk("hold_stable", {out_valid, zf, co, z}, {1'b1, hold});
         hold_v = out_valid && !out_ready && !clr;
         hold   = {zf, co, z};
         if (clr) begin
            q.delete();
         end else begin
            if (out_valid && out_ready) begin
               n_out++;
               chk("out_pending", (q.size() != 0), 1);
               if (q.size() != 0) chk("result", {zf, co, z}, q.pop_front());
            end
            if (in_valid && in_ready) q.push_back(model(mux, int'(sft), flin, a));
         end
      end
   end

   task automatic op(input logic [1:0] m, input logic [4:0] s, input logic f, input logic [31:0] av);
      int t;
      mux = m; sft = s; flin = f; a = av; in_valid = 1'b1;
      t = 0;
      @(negedge sys_clk);
      while (!in_ready && t < 100) begin
         @(negedge sys_clk);
         t++;
      end
      if (!in_ready) chk("accept_timeout", in_ready, 1);
      @(posedge sys_clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic lit(input string nm, input logic [1:0] m, input logic [4:0] s, input logic f,
                      input logic [31:0] av, input logic [31:0] ez, input logic eco, input logic ezf);
      chk({nm, "_model"}, model(m, int'(s), f, av), {ezf, eco, ez});
      op(m, s, f, av);
      @(negedge sys_clk);
      chk({nm, "_lat1"}, out_valid, 0);
      @(negedge sys_clk);
      chk({nm, "_lat2"}, out_valid, 1);
      chk({nm, "_out"}, {zf, co, z}, {ezf, eco, ez});
      @(posedge sys_clk); #1;
   endtask

   task automatic drain(input string nm);
      int t;
      t = 0;
      while (q.size() != 0 && t < 50) begin
         @(negedge sys_clk);
         t++;
      end
      chk(nm, q.size(), 0);
   endtask

   initial begin
      int n0;
      #1 resetl = 1'b0;
      #1;
      chk("reset_outs", {out_valid, zf, co, z}, 34'h0);
      chk("reset_in_ready", in_ready, 1);
      repeat (2) @(negedge sys_clk);
      #2 resetl = 1'b1;
      @(posedge sys_clk); #1;

      // directed vectors with hand-computed results
      lit("lsl1",  2'd0, 5'd1,  1'b1, 32'h8000_0001, 32'h0000_0003, 1'b1, 1'b0);
      lit("asr31", 2'd2, 5'd31, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
      lit("lsr31", 2'd1, 5'd31, 1'b0, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0);
      lit("ror1",  2'd3, 5'd1,  1'b0, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0);
      lit("lsr1z", 2'd1, 5'd1,  1'b0, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1);
      lit("lsl2z", 2'd0, 5'd2,  1'b0, 32'h4000_0000, 32'h0000_0000, 1'b1, 1'b1);
      lit("lsrf",  2'd1, 5'd4,  1'b1, 32'h0000_00F0, 32'hF000_000F, 1'b0, 1'b0);
      lit("sft0",  2'd0, 5'd0,  1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0);
      lit("ror4",  2'd3, 5'd4,  1'b0, 32'h1234_5678, 32'h8123_4567, 1'b1, 1'b0);

      // back-pressure: 8 back-to-back ops, out_ready low for cycles 3..6
      n0 = n_out;
      fork
         begin
            for (int i = 0; i < 8; i++)
               op(2'(i), 5'((i * 7 + 1) % 32), 1'(i & 1), 32'h0101_0000 * (i + 1) + 32'h9);
         end
         begin
            out_ready = 1'b1;
            repeat (3) @(posedge sys_clk);
            #1 out_ready = 1'b0;
            for (int i = 0; i < 4; i++) begin
               @(negedge sys_clk);
               chk("stall_in_ready", in_ready, 0);
               chk("stall_out_valid", out_valid, 1);
            end
            @(posedge sys_clk); #1;
            out_ready = 1'b1;
         end
      join
      drain("stall_drain");
      chk("stall_count", n_out - n0, 8);

      // flush with two ops in flight
      @(posedge sys_clk); #1;
      out_ready = 1'b0;
      op(2'd0, 5'd3, 1'b0, 32'h0000_00FF);
      op(2'd3, 5'd8, 1'b0, 32'hCAFE_F00D);
      clr = 1'b1;
      mux = 2'd1; sft = 5'd2; flin = 1'b0; a = 32'h0000_0010; in_valid = 1'b1;
      @(posedge sys_clk); #1;
      clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge sys_clk);
      chk("clr_out_valid", out_valid, 0);
      chk("clr_in_ready", in_ready, 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge sys_clk);
         chk("clr_no_out", out_valid, 0);
      end

      // asynchronous reset with the pipe full
      @(posedge sys_clk); #1;
      out_ready = 1'b0;
      op(2'd0, 5'd4, 1'b0, 32'h0000_1234);
      op(2'd1, 5'd4, 1'b0, 32'h0000_1234);
      @(negedge sys_clk);
      #2 resetl = 1'b0;
      #1;
      chk("rst_async_outs", {out_valid, zf, co, z}, 34'h0);
      chk("rst_async_in_ready", in_ready, 1);
      @(negedge sys_clk);
      #2 resetl = 1'b1;
      out_ready = 1'b1;
      @(posedge sys_clk); #1;
      lit("rst_first", 2'd3, 5'd4, 1'b0, 32'h1234_5678, 32'h8123_4567, 1'b1, 1'b0);

      // mixed ops under random back-pressure, checked by the scoreboard
      n0 = n_out;
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 40; i++)
               op(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom);
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge sys_clk); #1;
               out_ready = 1'($urandom_range(0, 1));
            end
            out_ready = 1'b1;
         end
      join
      drain("rand_drain");
      chk("rand_count", n_out - n0, 40);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
